// File: rtl/mul_digit_serial.sv
// Digit-serial N x N unsigned multiplier, full 2N-bit product.
// Horner over b, MSB digit first; one a*digit partial product per cycle.
module mul_digit_serial #(
  parameter int N = 255,
  parameter int W = 17
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] prod,
  output logic           busy
);

  localparam int DIGITS = N / W;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [N-1:0]   a_r;
  logic [N-1:0]   b_r;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_nxt;
  logic [2*N-1:0] prod_r;
  logic [CW-1:0]  cnt;
  logic [N+W-1:0] pp;
  logic           last;
  logic           take;
  logic           run;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign prod      = prod_r;

  assign last = (cnt == CW'(DIGITS - 1));
  assign take = in_ready && in_valid;
  assign run  = (state_q == RUN);

  // One Horner step: shift accumulator by a digit, add a * top digit of b.
  always_comb begin
    pp      = {{W{1'b0}}, a_r} * {{N{1'b0}}, b_r[N-1 -: W]};
    acc_nxt = (acc << W) + {{(N-W){1'b0}}, pp};
  end

  // Next-state logic: accept, iterate DIGITS times, wait for downstream.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = RUN;
      RUN:  if (last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand capture, shift-add iteration and product latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      prod_r <= '0;
      cnt    <= '0;
    end else begin
      unique case (1'b1)
        take: begin
          a_r <= a;
          b_r <= b;
          acc <= '0;
          cnt <= '0;
        end
        run: begin
          acc <= acc_nxt;
          b_r <= b_r << W;
          cnt <= cnt + CW'(1);
          if (last) prod_r <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_digit_serial.sv
// Bench for mul_digit_serial: directed corner cases plus random
// back-to-back traffic against plain a*b, for W=17 and W=51.
module tb_mul_digit_serial;

  localparam int N = 255;
  localparam int P = 2 * N;

  logic clk;
  logic rst_n;

  logic         in_valid  [2];
  logic         in_ready  [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic         busy      [2];
  logic [N-1:0] a         [2];
  logic [N-1:0] b         [2];
  logic [P-1:0] prod      [2];

  int digits [2];
  int total;
  int pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mul_digit_serial #(.N(N), .W(17)) u_w17 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .a         (a[0]),
    .b         (b[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .prod      (prod[0]),
    .busy      (busy[0])
  );

  mul_digit_serial #(.N(N), .W(51)) u_w51 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .a         (a[1]),
    .b         (b[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .prod      (prod[1]),
    .busy      (busy[1])
  );

  task automatic chk(input string tag,
                     input logic [P-1:0] got,
                     input logic [P-1:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [N-1:0] rnd();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 9))
      0:       v = '0;
      1:       v = '1;
      default: ;
    endcase
    return v[N-1:0];
  endfunction

  // Issue one operation on instance k, check latency, result and
  // stall behaviour, then complete the output handshake.
  task automatic run_op(input int k,
                        input logic [N-1:0] x,
                        input logic [N-1:0] y,
                        input int stall,
                        input bit poke,
                        output logic [P-1:0] got);
    logic [P-1:0] exp;
    logic [P-1:0] held;
    int lat;
    bit rdy_seen;
    bit unstable;
    exp = {{N{1'b0}}, x} * {{N{1'b0}}, y};
    got = '0;
    a[k] = x;
    b[k] = y;
    in_valid[k] = 1'b1;
    chk("in_ready_idle", P'(in_ready[k]), P'(1));
    @(negedge clk);
    in_valid[k] = 1'b0;
    a[k] = rnd();
    b[k] = rnd();
    lat = 0;
    rdy_seen = 1'b0;
    while (!out_valid[k] && lat < 100) begin
      rdy_seen |= in_ready[k];
      out_ready[k] = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    out_ready[k] = 1'b0;
    chk("in_ready_run", P'(rdy_seen), P'(0));
    chk("latency", P'(lat), P'(digits[k]));
    if (out_valid[k]) begin
      held = prod[k];
      got  = held;
      chk("prod", held, exp);
      unstable = 1'b0;
      for (int s = 0; s < stall; s++) begin
        if (poke) begin
          in_valid[k] = s[0] ? 1'b0 : 1'b1;
          a[k] = rnd();
          b[k] = rnd();
        end
        @(negedge clk);
        if (prod[k] !== held || !out_valid[k] || in_ready[k])
          unstable = 1'b1;
      end
      chk("hold", P'(unstable), P'(0));
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
      @(negedge clk);
      out_ready[k] = 1'b0;
      chk("idle_after",
          P'({in_ready[k], busy[k], out_valid[k]}), P'(3'b100));
    end
  endtask

  logic [P-1:0] got;
  logic [P-1:0] pm;
  logic [N-1:0] ones;
  logic [N-1:0] pm1;

  initial begin
    total = 0;
    pass  = 0;
    digits[0] = 15;
    digits[1] = 5;
    for (int k = 0; k < 2; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      a[k] = '0;
      b[k] = '0;
    end
    ones = '1;
    pm   = (P'(1) << 255) - P'(19);
    pm1  = pm[N-1:0] - N'(1);

    rst_n = 1'b0;
    in_valid[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state",
        P'({in_ready[0], busy[0], out_valid[0]}), P'(3'b100));
    chk("rst_prod", prod[0], '0);
    in_valid[0] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_no_capture", P'(busy[0]), P'(0));

    run_op(0, '0, ones, 0, 1'b0, got);
    run_op(0, N'(1), pm1, 0, 1'b0, got);
    run_op(0, ones, ones, 2, 1'b0, got);
    run_op(0, pm1, pm1, 1, 1'b0, got);
    chk("reduce", got % pm, P'(1));

    run_op(0, rnd(), rnd(), 5, 1'b1, got);
    run_op(0, N'(12345), N'(678), 0, 1'b0, got);

    in_valid[0] = 1'b1;
    a[0] = rnd();
    b[0] = rnd();
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_run",
        P'({in_ready[0], busy[0], out_valid[0]}), P'(3'b100));
    chk("rst_mid_prod", prod[0], '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, N'(3), N'(5), 0, 1'b0, got);

    in_valid[0] = 1'b1;
    a[0] = rnd();
    b[0] = rnd();
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (15) @(negedge clk);
    chk("done_reached", P'(out_valid[0]), P'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_done", P'(out_valid[0]), P'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 1000; i++)
      run_op(0, rnd(), rnd(), $urandom_range(0, 3), 1'b0, got);

    run_op(1, ones, ones, 0, 1'b0, got);
    for (int i = 0; i < 300; i++)
      run_op(1, rnd(), rnd(), $urandom_range(0, 3), 1'b0, got);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/mul_digit_serial.md
Name: mul_digit_serial

Overview:
- Multi-cycle, digit-serial 255x255-bit unsigned multiplier that produces the full 510-bit product consumed by the fast mod-p (p = 2^255 - 19) reduction stage.
- Sits directly upstream of that reduction stage in the field-multiply datapath.
- Trades area for latency: each cycle multiplies the full operand a by one W-bit digit of b.
- Uses valid/ready handshakes on both input and output so it can be stalled by the downstream stage.

Parameters:
- N, 255, operand width; product width is 2N.
- W, 17, digit width of b processed per cycle; must divide N exactly.
- DIGITS, N/W (15), derived localparam; number of RUN cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b are valid.
- in_ready  output  1  block can accept operands.
- a  input  N  multiplicand, unsigned, 0..2^N-1; need not be reduced mod p.
- b  input  N  multiplier, unsigned, 0..2^N-1.
- out_valid  output  1  product is valid.
- out_ready  input  1  downstream reducer accepts the product.
- prod  output  2N  a*b, exact, unsigned.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: rst_n is asynchronous, active-low. It forces the following:
  - state=IDLE, acc=0, prod=0, cnt=0.
  - Operand registers cleared; out_valid=0, busy=0.
  - in_ready follows state==IDLE, but no capture occurs while rst_n=0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On a clk edge with in_valid&&in_ready: a_r<=a, b_r<=b, acc<=0, cnt<=0, state->RUN.
- RUN:
  - in_ready=0; in_valid is ignored and operands are not sampled.
  - Horner, MSB digit first, each cycle:
    - acc <= (acc << W) + a_r * b_r[N-1 -: W]
    - b_r <= b_r << W
    - cnt <= cnt+1
  - On the cycle with cnt==DIGITS-1, the update is applied and state->DONE.
- DONE:
  - out_valid=1 and prod=acc.
  - prod is held stable while out_valid && !out_ready.
  - On out_valid&&out_ready: state->IDLE and out_valid->0.
  - prod keeps its last value; the downstream stage must not rely on it after the handshake.
- Latency: out_valid rises exactly DIGITS clk edges after the accepting edge (15 with defaults).
- Minimum issue interval is DIGITS+2 cycles (17 with defaults), with out_ready tied high. No overlap of operations.
- Arithmetic:
  - Partial product a_r*digit is N+W bits.
  - acc is 2N bits; the shift-add never overflows because the final value is < 2^(2N).
  - Intermediate truncation to 2N bits is exact; no carries are dropped.
- prod and out_valid are driven from registers; there is no combinational path from in_* to out_*.
- out_ready may be high in any state; it has no effect outside DONE.
- Reset asserted mid-RUN or in DONE:
  - The operation is abandoned immediately.
  - out_valid drops asynchronously.
  - After deassertion the block is in IDLE, accepting.
- Operand changes on a/b while not in IDLE have no effect.
- in_valid held high across completion:
  - A new operation is accepted on the first edge in IDLE.
  - This is the edge after the output handshake.
- Zero operands are handled normally: full DIGITS latency, prod=0.

Test Plan:
- a=0, b=2^255-1:
  - prod=0.
  - out_valid exactly 15 cycles after acceptance.
  - in_ready low for the whole operation.
- a=1, b=2^255-20 (p-1):
  - prod=2^255-20.
- a=b=2^255-1:
  - prod=2^510-2^256+1 (max-width check, no overflow).
- a=b=2^255-20:
  - prod=2^510-40*2^255+400.
  - Feed prod to the reducer; its result must be 1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE: prod and out_valid stay stable.
  - Toggle in_valid with new operands during DONE: no capture.
  - Release out_ready: IDLE next cycle, then the new operands are accepted.
- Reset mid-operation:
  - Pulse rst_n low at RUN cycle 7: outputs go to 0 immediately.
  - Next op a=3, b=5 yields prod=15.
- Random regression:
  - 1000 back-to-back random pairs with random out_ready stalls, compared against a golden a*b model.
  - Repeat with W=51 (DIGITS=5): latency 5.
